// File: rtl/bit_word_packer.sv
// Serial-to-parallel packer: collects single bits into WIDTH-bit words with
// valid/ready handshakes on both sides, plus an explicit flush that emits a
// partial word together with its bit count.
module bit_word_packer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       bit_valid,
   input  logic                       bit_in,
   output logic                       bit_ready,
   input  logic                       flush,
   output logic                       word_valid,
   input  logic                       word_ready,
   output logic [WIDTH-1:0]           word_data,
   output logic [$clog2(WIDTH+1)-1:0] word_len,
   output logic                       busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   // Packer state: EMPTY (cnt=0), FILL (0<cnt<WIDTH), FULL (cnt=WIDTH),
   // DRAIN (flush pending, partial word waiting for the output register).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             word_valid_q, word_valid_d;
   logic [WIDTH-1:0] word_data_q, word_data_d;
   logic [CW-1:0]    word_len_q, word_len_d;

   logic             flush_pend;
   logic             out_free;
   logic             xfer;
   logic             accept;
   logic             flush_set;
   logic [WIDTH-1:0] base_acc;
   logic [CW-1:0]    base_cnt;
   logic [CW-1:0]    pos;

   // The pending-flush flag is exactly the DRAIN state.
   assign flush_pend = (state_q == DRAIN);

   // Output register can take a new word if empty or being handed off now.
   assign out_free = !word_valid_q | word_ready;

   // Move the accumulator into the output register: full word, or flushed partial.
   assign xfer = out_free & ((cnt_q == CNT_FULL) | (flush_pend & (cnt_q != '0)));

   // A bit can enter when there is room, or when room is being made this cycle.
   assign bit_ready = !flush_pend & ((cnt_q < CNT_FULL) | xfer);
   assign accept    = bit_valid & bit_ready;

   // Accumulator view after any transfer this cycle; a bit accepted alongside
   // a transfer lands in the cleared accumulator, so there is no bubble.
   assign base_acc = xfer ? '0 : acc_q;
   assign base_cnt = xfer ? '0 : cnt_q;
   assign cnt_d    = base_cnt + CW'(accept);

   // Write position of the incoming bit. accept implies base_cnt < WIDTH.
   assign pos = MSB_FIRST ? (CNT_LAST - base_cnt) : base_cnt;

   // Per-position accumulator update.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_acc
         assign acc_d[gi] = (accept && (pos == CW'(gi))) ? bit_in : base_acc[gi];
      end
   endgenerate

   // Flush only matters when a partial word remains after this cycle; a flush
   // on an empty packer, one already pending, or one that meets a completed
   // full word changes nothing (the full word goes out normally).
   assign flush_set = flush & !flush_pend & (cnt_d != '0) & (cnt_d != CNT_FULL);

   // Next-state logic for the packer FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (flush_set)
               state_d = DRAIN;
            else if (accept)
               state_d = FILL;
         end
         FILL: begin
            if (flush_set)
               state_d = DRAIN;
            else if (cnt_d == CNT_FULL)
               state_d = FULL;
         end
         FULL: begin
            if (xfer) begin
               if (flush_set)
                  state_d = DRAIN;
               else if (accept)
                  state_d = FILL;
               else
                  state_d = EMPTY;
            end
         end
         DRAIN: begin
            if (xfer)
               state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Output word register: load on transfer, release on handoff.
   always_comb begin
      word_valid_d = word_valid_q;
      word_data_d  = word_data_q;
      word_len_d   = word_len_q;
      if (xfer) begin
         word_valid_d = 1'b1;
         word_data_d  = acc_q;
         word_len_d   = cnt_q;
      end else if (word_ready) begin
         word_valid_d = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= EMPTY;
      else
         state_q <= state_d;
   end

   // Datapath registers: accumulator, bit count and output word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         word_valid_q <= 1'b0;
         word_data_q  <= '0;
         word_len_q   <= '0;
      end else begin
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         word_valid_q <= word_valid_d;
         word_data_q  <= word_data_d;
         word_len_q   <= word_len_d;
      end
   end

   assign word_valid = word_valid_q;
   assign word_data  = word_data_q;
   assign word_len   = word_len_q;
   assign busy       = (cnt_q != '0) | flush_pend | word_valid_q;

endmodule

// File: tb/tb_bit_word_packer.sv
// Directed bench for bit_word_packer: LSB-first and MSB-first instances share
// one stimulus stream; every expectation below is hand-computed.
module tb_bit_word_packer;

   logic       clk = 1'b0;
   logic       rst;
   logic       bit_valid, bit_in, flush, word_ready;
   logic       bit_ready0, word_valid0, busy0;
   logic [7:0] word_data0;
   logic [3:0] word_len0;
   logic       bit_ready1, word_valid1, busy1;
   logic [7:0] word_data1;
   logic [3:0] word_len1;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] t3_words [3] = '{8'hA5, 8'h3C, 8'hFF};

   always #5 clk = ~clk;

   bit_word_packer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready0),
      .flush(flush), .word_valid(word_valid0), .word_ready(word_ready),
      .word_data(word_data0), .word_len(word_len0), .busy(busy0));

   bit_word_packer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready1),
      .flush(flush), .word_valid(word_valid1), .word_ready(word_ready),
      .word_data(word_data1), .word_len(word_len1), .busy(busy1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send n bits, bits[0] first, one per cycle, expecting bit_ready each cycle.
   task automatic send_bits(input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         bit_valid = 1'b1;
         bit_in    = bits[i];
         chk("send_bit_ready", bit_ready0, 1);
         tick();
      end
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; flush = 1'b0; word_ready = 1'b1;
      #1;
      chk("rst_word_valid", word_valid0, 0);
      chk("rst_word_data", word_data0, 0);
      chk("rst_word_len", word_len0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_bit_ready", bit_ready0, 1);
      tick(); tick();
      rst = 1'b0;

      // T1/T2: bits 1,0,1,1,0,0,0,0
      send_bits(32'h0D, 8);
      chk("t1_valid_latency", word_valid0, 0);
      chk("t1_busy_full", busy0, 1);
      tick();
      chk("t1_valid", word_valid0, 1);
      chk("t1_data", word_data0, 8'h0D);
      chk("t1_len", word_len0, 8);
      chk("t2_msb_data", word_data1, 8'hB0);
      chk("t2_msb_len", word_len1, 8);
      tick();
      chk("t1_handoff", word_valid0, 0);
      chk("t1_idle_busy", busy0, 0);

      // T3: 24 continuous bits, words every 8 cycles
      for (int i = 0; i < 24; i++) begin
         bit_valid = 1'b1;
         bit_in    = logic'((32'h00FF3CA5 >> i) & 1);
         chk("t3_bit_ready", bit_ready0, 1);
         tick();
         chk("t3_valid", word_valid0, 32'((i == 8) || (i == 16)));
         if ((i == 8) || (i == 16))
            chk("t3_data", word_data0, t3_words[i / 8 - 1]);
      end
      bit_valid = 1'b0;
      tick();
      chk("t3_valid_last", word_valid0, 1);
      chk("t3_data_last", word_data0, t3_words[2]);
      tick();
      chk("t3_end_valid", word_valid0, 0);

      // T4: backpressure, 16 bits with word_ready=0
      word_ready = 1'b0;
      send_bits(32'hC35A, 16);
      chk("t4_bit_ready_stall", bit_ready0, 0);
      chk("t4_hold_valid", word_valid0, 1);
      chk("t4_hold_data", word_data0, 8'h5A);
      bit_valid = 1'b1; bit_in = 1'b1;   // bit 17 offered while stalled
      tick();
      chk("t4_still_stalled", bit_ready0, 0);
      chk("t4_stable_data", word_data0, 8'h5A);
      chk("t4_stable_len", word_len0, 8);
      word_ready = 1'b1;
      #1;
      chk("t4_ready_on_release", bit_ready0, 1);
      tick();
      bit_valid = 1'b0; bit_in = 1'b0;
      chk("t4_second_valid", word_valid0, 1);
      chk("t4_second_data", word_data0, 8'hC3);
      tick();
      chk("t4_second_handoff", word_valid0, 0);
      chk("t4_busy_partial", busy0, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4_flush_ready", bit_ready0, 0);
      tick();
      chk("t4_bit17_valid", word_valid0, 1);
      chk("t4_bit17_data", word_data0, 8'h01);
      chk("t4_bit17_len", word_len0, 1);
      tick();

      // T5: bits 1,1,0 then flush
      send_bits(32'h3, 3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_pend_ready", bit_ready0, 0);
      chk("t5_pend_valid", word_valid0, 0);
      chk("t5_pend_busy", busy0, 1);
      tick();
      chk("t5_valid", word_valid0, 1);
      chk("t5_data", word_data0, 8'h03);
      chk("t5_len", word_len0, 3);
      chk("t5_msb_data", word_data1, 8'hC0);
      chk("t5_ready_after", bit_ready0, 1);
      tick();
      chk("t5_handoff", word_valid0, 0);
      flush = 1'b1;                      // flush on empty packer
      tick();
      flush = 1'b0;
      chk("t5_empty_flush_busy", busy0, 0);
      tick();
      chk("t5_empty_flush_noword", word_valid0, 0);
      // flush together with the third bit: bits 1,0,1
      send_bits(32'h1, 2);
      bit_valid = 1'b1; bit_in = 1'b1; flush = 1'b1;
      tick();
      bit_valid = 1'b0; bit_in = 1'b0; flush = 1'b0;
      chk("t5_coflush_ready", bit_ready0, 0);
      tick();
      chk("t5_coflush_data", word_data0, 8'h05);
      chk("t5_coflush_len", word_len0, 3);
      tick();

      // T6: async reset with a word pending and 5 bits in the accumulator
      word_ready = 1'b0;
      send_bits(32'h1FFF, 13);
      chk("t6_pre_valid", word_valid0, 1);
      chk("t6_pre_busy", busy0, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid", word_valid0, 0);
      chk("t6_rst_busy", busy0, 0);
      chk("t6_rst_data", word_data0, 0);
      chk("t6_rst_len", word_len0, 0);
      rst = 1'b0;
      word_ready = 1'b1;
      tick();
      send_bits(32'h96, 8);
      chk("t6_clean_latency", word_valid0, 0);
      tick();
      chk("t6_clean_valid", word_valid0, 1);
      chk("t6_clean_data", word_data0, 8'h96);
      chk("t6_clean_len", word_len0, 8);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
